ps2_rx_ctrl: RTL and testbench
==============================

// Module: ps2_rx_ctrl
//
// PURPOSE
//   Receive controller for the PS/2 keyboard port.
//   - Synchronises and de-glitches the PS/2 clock/data lines and detects falling edges of the keyboard clock.
//   - Sequences the 11-bit frame (start, 8 data LSB-first, odd parity, stop) through a small FSM, with error checks and an inactivity watchdog.
//   - Hands each good scan-code byte to the keyboard decoder over a single-entry valid/ready buffer.
//   - Runs entirely in the system clock domain; no derived clocks.
//
// PARAMETERS
//   SYNC_STAGES  2      flops in each input synchroniser chain (>=2)
//   FILTER_LEN   4      consecutive equal samples required before the filtered ps2 clock changes
//   TIMEOUT_CYC  14780  system cycles without a ps2 clock fall (mid-frame) before abort; 1 ms at 14.78 MHz
//
// PORTS
//   clk_i         in   1  system clock, 14.78 MHz
//   reset         in   1  synchronous, active-high reset
//   ps2_clk_i     in   1  raw PS/2 clock pin, asynchronous
//   ps2_data_i    in   1  raw PS/2 data pin, asynchronous
//   code_o        out  8  received scan-code byte, stable while valid_o=1
//   valid_o       out  1  code_o holds an unconsumed byte
//   ready_i       in   1  consumer accepts code_o when valid_o & ready_i
//   parity_err_o  out  1  1-cycle pulse: frame dropped, bad odd parity
//   frame_err_o   out  1  1-cycle pulse: frame dropped, bad stop bit or timeout
//   overrun_o     out  1  1-cycle pulse: good byte dropped, buffer full
//   busy_o        out  1  FSM not in IDLE
//
// BEHAVIOUR
//   Reset (sync, active-high, overrides everything)
//   - code_o=0; valid_o=0; all pulses=0; busy_o=0; FSM=IDLE.
//   - Bit counter, shift register, timeout counter and filter all cleared.
//   - Filtered ps2 clock reset to 1.
//   - Reset mid-frame discards the partial frame with no error pulse.
//
//   Input conditioning
//   - Each pin passes through SYNC_STAGES flops.
//   - Filtered clock takes the synchronised value only after FILTER_LEN consecutive identical samples.
//   - fall = filtered clock 1->0, registered: a 1-cycle strobe.
//   - Data is sampled from its synchroniser output in the fall cycle.
//
//   FSM
//   - IDLE:
//     - fall & data=0: go to SHIFT; bitcnt=0; timeout counter=0.
//     - fall & data=1: ignore, stay in IDLE.
//   - SHIFT:
//     - each fall: shift data in at MSB of a 10-bit register (data LSB first, then parity, then stop); bitcnt+1; timeout counter=0.
//     - no fall: timeout counter+1.
//     - fall with bitcnt==9 (stop bit): go to CHECK.
//     - timeout counter reaches TIMEOUT_CYC-1: frame_err_o pulse, go to IDLE; this takes priority over a same-cycle fall.
//   - CHECK (exactly one cycle, then IDLE):
//     - stop bit == 0: frame_err_o.
//     - else XOR(data, parity) == 0: parity_err_o.
//     - else good byte: if the buffer is empty, or being drained this cycle (valid_o & ready_i), load code_o and set valid_o next cycle.
//     - else (buffer full, not draining): overrun_o pulse; code_o unchanged.
//
//   Handshake and latency
//   - valid_o rises 2 cycles after the stop-bit fall strobe.
//   - valid_o stays high and code_o stays stable until the cycle valid_o & ready_i.
//   - valid_o clears the cycle after that transfer, unless a same-cycle reload re-asserts it with the new byte.
//   - ready_i while valid_o=0 has no effect.
//   - At most one error/overrun pulse per frame.
//
// TESTING
//   - Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), ps2 clk period 1000 cycles, ready_i=1 -> code_o=0x1C, valid_o=1 for 1 cycle, 2 cycles after the stop fall; no error pulses.
//   - 0x1C sent with parity=1 -> one parity_err_o pulse; valid_o stays 0; FSM back in IDLE.
//   - 0xF0 sent with parity 1, stop 0 -> one frame_err_o pulse; no valid_o.
//   - Timeout and recovery:
//     - Start bit plus 4 data bits, then clock held high for TIMEOUT_CYC cycles -> frame_err_o pulse, busy_o=0.
//     - Follow with a full 0xF0 frame -> code_o=0xF0 valid.
//   - Overrun: ready_i=0, send 0x1C then 0xF0 -> code_o stays 0x1C, one overrun_o pulse; ready_i=1 -> one transfer, then valid_o=0.
//   - Glitch and reset:
//     - 2-cycle low glitch on ps2_clk_i in IDLE or SHIFT -> no bit counted.
//     - reset asserted after the 6th fall -> all outputs 0, next good frame received correctly.

Source files
------------

// File: rtl/ps2_rx_ctrl_if.sv
`timescale 1ns/1ps
// Consumer-side bundle of the PS/2 receiver: scan-code buffer handshake,
// error/overrun strobes and the busy flag.
interface ps2_rx_ctrl_if;
    logic [7:0] code_o;
    logic       valid_o;
    logic       ready_i;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    // The receiver drives the byte and status lines.
    modport master (
        output code_o, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o,
        input  ready_i
    );

    // The keyboard decoder consumes them and drives ready.
    modport slave (
        input  code_o, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o,
        output ready_i
    );
endinterface

// File: rtl/ps2_rx_ctrl.sv
`timescale 1ns/1ps
// PS/2 keyboard receive controller: synchronises and filters the PS/2 pins,
// frames 11-bit words on keyboard-clock falls, checks stop/parity, runs a
// mid-frame watchdog and presents good bytes through a one-entry buffer.
module ps2_rx_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 14780
) (
    input  logic          clk_i,
    input  logic          reset,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    ps2_rx_ctrl_if.master kbd
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_s, data_s;
    logic                   filt_clk_q, filt_clk_d;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   fall_q;
    state_t                 state_q, state_d;
    logic [3:0]             bitcnt_q;
    logic [9:0]             shreg_q;
    logic [TW-1:0]          tcnt_q;
    logic                   timeout_hit;
    logic [7:0]             code_q;
    logic                   valid_q;
    logic                   perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                   load;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Input synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_s == filt_clk_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_clk_d = clk_s;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    // Filter state and the registered 1->0 strobe of the filtered clock.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= filt_clk_q & ~filt_clk_d;
        end
    end

    assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYC - 1));

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; the watchdog wins over a same-cycle fall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fall_q && !data_s) state_d = S_SHIFT;
            S_SHIFT: begin
                if (timeout_hit)                        state_d = S_IDLE;
                else if (fall_q && bitcnt_q == 4'd9)    state_d = S_CHECK;
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: error/overrun decisions and buffer load request.
    always_comb begin
        perr_d = 1'b0;
        ferr_d = 1'b0;
        ovr_d  = 1'b0;
        load   = 1'b0;
        case (state_q)
            S_SHIFT: ferr_d = timeout_hit;
            S_CHECK: begin
                // shreg_q = {stop, parity, data[7:0]}
                if (!shreg_q[9])                  ferr_d = 1'b1;
                else if (!(^shreg_q[8:0]))        perr_d = 1'b1;
                else if (!valid_q || kbd.ready_i) load   = 1'b1;
                else                              ovr_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame datapath: bit counter, LSB-first shift register, watchdog.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            bitcnt_q <= '0;
            shreg_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (fall_q && !data_s) bitcnt_q <= '0;
                end
                S_SHIFT: begin
                    if (fall_q) begin
                        shreg_q  <= {data_s, shreg_q[9:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        tcnt_q   <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single-entry output buffer and registered status pulses.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (load) begin
                code_q  <= shreg_q[7:0];
                valid_q <= 1'b1;
            end else if (valid_q && kbd.ready_i) begin
                valid_q <= 1'b0;
            end
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    assign kbd.code_o       = code_q;
    assign kbd.valid_o      = valid_q;
    assign kbd.parity_err_o = perr_q;
    assign kbd.frame_err_o  = ferr_q;
    assign kbd.overrun_o    = ovr_q;
    assign kbd.busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
`timescale 1ns/1ps
// Bench for ps2_rx_ctrl: bit-banged PS/2 frames, expected bytes queued at
// stimulus time and compared with bytes the monitor captures on transfer.
module tb_ps2_rx_ctrl;
    localparam int TOUT = 2000;
    // Pin fall -> 2 sync flops -> 4 filter samples (strobe on the 4th) ->
    // CHECK -> valid: valid is seen 8 cycles after the stop-bit pin fall.
    localparam int LAT = 8;

    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    ps2_rx_ctrl_if kbd_if();

    ps2_rx_ctrl #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(TOUT)) dut (
        .clk_i(clk), .reset(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data), .kbd(kbd_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    logic [7:0] exp_q[$], got_q[$];
    int perr_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, valid_cyc = 0;
    int last_lat = -1, stop_fall_cyc = 0;
    logic valid_prev = 1'b0;

    // Monitor: capture transfers and count pulses away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            valid_prev = 1'b0;
        end else begin
            if (kbd_if.valid_o && kbd_if.ready_i) got_q.push_back(kbd_if.code_o);
            if (kbd_if.parity_err_o) perr_cnt++;
            if (kbd_if.frame_err_o)  ferr_cnt++;
            if (kbd_if.overrun_o)    ovr_cnt++;
            if (kbd_if.valid_o)      valid_cyc++;
            if (kbd_if.valid_o && !valid_prev) last_lat = cyc - stop_fall_cyc;
            valid_prev = kbd_if.valid_o;
        end
    end

    function automatic logic [10:0] frame(logic [7:0] d, logic flip, logic stop);
        return {stop, (~^d) ^ flip, d, 1'b0};
    endfunction

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive frame bits lo..hi-1: data set while clock high, then a fall.
    task automatic send_bits(logic [10:0] bits, int lo, int hi, int half);
        for (int i = lo; i < hi; i++) begin
            ps2_data = bits[i];
            wait_cycles(half);
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wait_cycles(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        kbd_if.ready_i = 1'b1;
        wait_cycles(5);
        checks++; if (kbd_if.code_o !== 8'h00) begin errors++; $display("FAIL reset_code: got %0h expected 0", kbd_if.code_o); end
        checks++; if (kbd_if.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", kbd_if.valid_o); end
        checks++; if ({kbd_if.busy_o, kbd_if.parity_err_o, kbd_if.frame_err_o, kbd_if.overrun_o} !== 4'b0)
            begin errors++; $display("FAIL reset_flags: got %0b expected 0", {kbd_if.busy_o, kbd_if.parity_err_o, kbd_if.frame_err_o, kbd_if.overrun_o}); end
        rst = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_good_frame;
        int v0, e0;
        logic [7:0] e, g;
        v0 = valid_cyc; e0 = perr_cnt + ferr_cnt + ovr_cnt; last_lat = -1;
        exp_q.push_back(8'h1C);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 11, 500);
        wait_cycles(20);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL good_count: got %0d expected 1", got_q.size()); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin errors++; $display("FAIL good_code: got %0h expected %0h", g, e); end
        end
        checks++; if (last_lat != LAT) begin errors++; $display("FAIL good_latency: got %0d expected %0d", last_lat, LAT); end
        checks++; if (valid_cyc - v0 != 1) begin errors++; $display("FAIL good_valid_len: got %0d expected 1", valid_cyc - v0); end
        checks++; if (perr_cnt + ferr_cnt + ovr_cnt - e0 != 0) begin errors++; $display("FAIL good_no_err: got %0d expected 0", perr_cnt + ferr_cnt + ovr_cnt - e0); end
    endtask

    task automatic test_parity;
        int p0, f0;
        p0 = perr_cnt; f0 = ferr_cnt;
        send_bits(frame(8'h1C, 1'b1, 1'b1), 0, 11, 100);
        wait_cycles(20);
        checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL parity_pulse: got %0d expected 1", perr_cnt - p0); end
        checks++; if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL parity_no_ferr: got %0d expected 0", ferr_cnt - f0); end
        checks++; if (got_q.size() != 0 || kbd_if.valid_o !== 1'b0) begin errors++; $display("FAIL parity_no_valid: got %0d expected 0", got_q.size()); end
        checks++; if (kbd_if.busy_o !== 1'b0) begin errors++; $display("FAIL parity_idle: got %0b expected 0", kbd_if.busy_o); end
    endtask

    task automatic test_frame_err;
        int p0, f0;
        p0 = perr_cnt; f0 = ferr_cnt;
        send_bits(frame(8'hF0, 1'b0, 1'b0), 0, 11, 100);
        wait_cycles(20);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL stop_pulse: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (perr_cnt - p0 != 0) begin errors++; $display("FAIL stop_no_perr: got %0d expected 0", perr_cnt - p0); end
        checks++; if (got_q.size() != 0 || kbd_if.valid_o !== 1'b0) begin errors++; $display("FAIL stop_no_valid: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_timeout;
        int f0, n;
        logic [7:0] e, g;
        f0 = ferr_cnt;
        send_bits(frame(8'h0F, 1'b0, 1'b1), 0, 5, 100);
        wait_cycles(TOUT - 200);
        checks++; if (kbd_if.busy_o !== 1'b1 || ferr_cnt != f0) begin errors++; $display("FAIL timeout_early: got busy=%0b errs=%0d expected busy=1 errs=0", kbd_if.busy_o, ferr_cnt - f0); end
        n = 0;
        while (ferr_cnt == f0 && n < 400) begin wait_cycles(1); n++; end
        wait_cycles(2);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL timeout_pulse: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (kbd_if.busy_o !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %0b expected 0", kbd_if.busy_o); end
        exp_q.push_back(8'hF0);
        send_bits(frame(8'hF0, 1'b0, 1'b1), 0, 11, 100);
        wait_cycles(20);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL recover_count: got %0d expected 1", got_q.size()); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin errors++; $display("FAIL recover_code: got %0h expected %0h", g, e); end
        end
    endtask

    task automatic test_overrun;
        int o0;
        logic [7:0] e, g;
        o0 = ovr_cnt;
        kbd_if.ready_i = 1'b0;
        exp_q.push_back(8'h1C);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 11, 100);
        send_bits(frame(8'hF0, 1'b0, 1'b1), 0, 11, 100);
        wait_cycles(20);
        checks++; if (kbd_if.code_o !== 8'h1C || kbd_if.valid_o !== 1'b1) begin errors++; $display("FAIL ovr_hold: got %0h/%0b expected 1c/1", kbd_if.code_o, kbd_if.valid_o); end
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected 1", ovr_cnt - o0); end
        kbd_if.ready_i = 1'b1;
        wait_cycles(3);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", got_q.size()); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin errors++; $display("FAIL ovr_code: got %0h expected %0h", g, e); end
        end
        checks++; if (kbd_if.valid_o !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %0b expected 0", kbd_if.valid_o); end
    endtask

    task automatic test_glitch;
        logic [10:0] f;
        logic [7:0] e, g;
        ps2_data = 1'b0; ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cycles(20);
        checks++; if (kbd_if.busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %0b expected 0", kbd_if.busy_o); end
        f = frame(8'h3A, 1'b0, 1'b1);
        exp_q.push_back(8'h3A);
        send_bits(f, 0, 3, 100);
        wait_cycles(40);
        ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1;
        send_bits(f, 3, 11, 100);
        wait_cycles(20);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", got_q.size()); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin errors++; $display("FAIL glitch_code: got %0h expected %0h", g, e); end
        end
    endtask

    task automatic test_reset_midframe;
        int e0;
        logic [7:0] e, g;
        e0 = perr_cnt + ferr_cnt + ovr_cnt;
        send_bits(frame(8'hAA, 1'b0, 1'b1), 0, 6, 100);
        wait_cycles(10);
        rst = 1'b1;
        wait_cycles(2);
        checks++; if ({kbd_if.code_o, kbd_if.valid_o, kbd_if.busy_o} !== 10'b0) begin errors++; $display("FAIL midrst_outs: got %0h expected 0", {kbd_if.code_o, kbd_if.valid_o, kbd_if.busy_o}); end
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(10);
        checks++; if (perr_cnt + ferr_cnt + ovr_cnt - e0 != 0) begin errors++; $display("FAIL midrst_no_err: got %0d expected 0", perr_cnt + ferr_cnt + ovr_cnt - e0); end
        exp_q.push_back(8'h12);
        send_bits(frame(8'h12, 1'b0, 1'b1), 0, 11, 100);
        wait_cycles(20);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", got_q.size()); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin errors++; $display("FAIL midrst_code: got %0h expected %0h", g, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, g;
        exp_q.push_back(8'h1C);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 11, 100);
        exp_q.push_back(8'hF0);
        send_bits(frame(8'hF0, 1'b0, 1'b1), 0, 11, 100);
        wait_cycles(20);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL b2b_count: got 0 expected byte %0d", k); end
            else begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL b2b_code: got %0h expected %0h", g, e); end
            end
        end
    endtask

    initial begin
        kbd_if.ready_i = 1'b1;
        test_reset();
        test_good_frame();
        test_parity();
        test_frame_err();
        test_timeout();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
